avm_width_adapter: RTL

AVM_WIDTH_ADAPTER -- requirements
Module: avm_width_adapter

---
 rtl/avm_width_adapter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/avm_width_adapter.sv
// avm_width_adapter: splits wide kernel Avalon-MM bursts into narrow memory beats and reassembles read data
module avm_width_adapter #(
    parameter int AWIDTH        = 32,
    parameter int KWIDTH_BYTES  = 64,
    parameter int MWIDTH_BYTES  = 32,
    parameter int KBURST_WIDTH  = 5,
    parameter int PENDING_WIDTH = 10
) (
    input  logic                                                         clock,
    input  logic                                                         reset,
    input  logic [AWIDTH-1:0]                                            k_address,
    input  logic                                                         k_read,
    input  logic                                                         k_write,
    input  logic [8*KWIDTH_BYTES-1:0]                                    k_writedata,
    input  logic [KWIDTH_BYTES-1:0]                                      k_byteenable,
    input  logic [KBURST_WIDTH-1:0]                                      k_burstcount,
    output logic                                                         k_waitrequest,
    output logic [8*KWIDTH_BYTES-1:0]                                    k_readdata,
    output logic                                                         k_readdatavalid,
    output logic                                                         k_writeack,
    output logic [AWIDTH-1:0]                                            m_address,
    output logic                                                         m_read,
    output logic                                                         m_write,
    output logic [8*MWIDTH_BYTES-1:0]                                    m_writedata,
    output logic [MWIDTH_BYTES-1:0]                                      m_byteenable,
    output logic [KBURST_WIDTH+$clog2(KWIDTH_BYTES/MWIDTH_BYTES)-1:0]    m_burstcount,
    input  logic                                                         m_waitrequest,
    input  logic [8*MWIDTH_BYTES-1:0]                                    m_readdata,
    input  logic                                                         m_readdatavalid,
    input  logic                                                         m_writeack,
    output logic                                                         o_active
);
    localparam int RATIO = KWIDTH_BYTES / MWIDTH_BYTES;
    localparam int KW    = 8 * KWIDTH_BYTES;
    localparam int MW    = 8 * MWIDTH_BYTES;
    localparam int RB    = $clog2(RATIO);
    localparam int PW1   = PENDING_WIDTH + 1;
    localparam logic [RB-1:0]            LAST = RB'(RATIO - 1);
    localparam logic [PENDING_WIDTH-1:0] PMAX = '1;

    typedef enum logic [1:0] {IDLE, RD_CMD, WR_DATA, WR_GAP} state_t;

    state_t                     state, state_nxt;
    logic [AWIDTH-1:0]          addr_q;
    logic [KBURST_WIDTH-1:0]    burst_q, words_left;
    logic [KW-1:0]              wdata_q, rdata_q;
    logic [KWIDTH_BYTES-1:0]    be_q;
    logic [RB-1:0]              idx, beat_cnt, ack_cnt;
    logic                       rvalid_q;
    logic [PENDING_WIDTH-1:0]   pending, pending_nxt;
    logic                       beat_acc, wrap, more, rd_acc, wr_cap;
    logic [PW1-1:0]             add_amt, sub_amt, p_add, p_sub;

    // memory-side command outputs depend only on registered state, never on m_waitrequest
    assign m_read          = state == RD_CMD;
    assign m_write         = state == WR_DATA;
    assign m_address       = addr_q;
    assign m_burstcount    = {burst_q, {RB{1'b0}}};
    assign m_writedata     = wdata_q[idx*MW +: MW];
    assign m_byteenable    = be_q[idx*MWIDTH_BYTES +: MWIDTH_BYTES];
    assign k_readdata      = rdata_q;
    assign k_readdatavalid = rvalid_q;
    assign k_writeack      = m_writeack && ack_cnt == LAST;
    assign o_active        = state != IDLE || pending != '0;

    // handshakes, next state and pending-counter arithmetic
    always_comb begin
        beat_acc      = state == WR_DATA && !m_waitrequest;
        wrap          = beat_acc && idx == LAST;
        more          = words_left != KBURST_WIDTH'(1);
        rd_acc        = state == IDLE && k_read && !k_write;
        wr_cap        = k_write && (state == IDLE || state == WR_GAP || (wrap && more));
        k_waitrequest = state == RD_CMD || (state == WR_DATA && !(wrap && more));
        state_nxt     = state;
        case (state)
            IDLE:    state_nxt = k_write ? WR_DATA : (k_read ? RD_CMD : IDLE);
            RD_CMD:  state_nxt = m_waitrequest ? RD_CMD : IDLE;
            WR_DATA: state_nxt = !wrap ? WR_DATA : (!more ? IDLE : (k_write ? WR_DATA : WR_GAP));
            WR_GAP:  state_nxt = k_write ? WR_DATA : WR_GAP;
            default: state_nxt = IDLE;
        endcase
        add_amt     = rd_acc ? PW1'(k_burstcount) : PW1'(wr_cap);
        sub_amt     = PW1'(rvalid_q) + PW1'(k_writeack);
        p_add       = PW1'(pending) + add_amt;
        p_sub       = p_add < sub_amt ? '0 : p_add - sub_amt;
        pending_nxt = p_sub > PW1'(PMAX) ? PMAX : p_sub[PENDING_WIDTH-1:0];
    end

    // state register
    always_ff @(posedge clock)
        state <= reset ? IDLE : state_nxt;

    // command capture and narrow-lane sequencing for write bursts
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            burst_q    <= '0;
            words_left <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            idx        <= '0;
        end else begin
            if (state == IDLE && (k_write || k_read)) begin
                addr_q     <= k_address;
                burst_q    <= k_burstcount;
                words_left <= k_burstcount;
            end
            if (wr_cap) begin
                wdata_q <= k_writedata;
                be_q    <= k_byteenable;
            end
            if (state == IDLE)
                idx <= '0;
            else if (beat_acc)
                idx <= idx + 1'b1;
            if (wrap)
                words_left <= words_left - 1'b1;
        end
    end

    // read beats shift in from the top so the first beat ends up in lane 0
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q  <= '0;
            beat_cnt <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= m_readdatavalid && beat_cnt == LAST;
            if (m_readdatavalid) begin
                rdata_q  <= {m_readdata, rdata_q[KW-1:MW]};
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // narrow write-ack counting and outstanding-word tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_cnt <= '0;
            pending <= '0;
        end else begin
            if (m_writeack)
                ack_cnt <= ack_cnt + 1'b1;
            pending <= pending_nxt;
        end
    end
endmodule
